// File: rtl/cpu_types_pkg.sv
// Shared types for the cache/RAM side of the core complex.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic {
      ARB  = 1'b0,
      XFER = 1'b1
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first requester at or after ptr, wrapping modulo N.
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          valid,
   output logic [IW-1:0] idx
);

   logic [N-1:0] rot;

   // Rotate so bit 0 is the requester sitting at the pointer.
   assign rot = N'({req, req} >> ptr);

   // Scan from the far end down so the nearest requester wins.
   always_comb begin
      int sum;
      sum   = 0;
      valid = 1'b0;
      idx   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            sum = int'(ptr) + k;
            if (sum >= N) sum = sum - N;
            valid = 1'b1;
            idx   = IW'(sum);
         end
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one RAM port between per-core icache/dcache requesters.
// dcache beats icache; round-robin within each class; a dcache owner
// keeps the port across both words of a block.
//
// state | meaning
// ARB   | bubble cycle, picking the next owner, RAM idle
// XFER  | owner's request muxed onto the RAM, waiting for ACCESS
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int CPUS = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [CPUS-1:0]   iREN,
   input  word_t             iaddr  [CPUS],
   output logic [CPUS-1:0]   iwait,
   output word_t             iload  [CPUS],
   input  logic [CPUS-1:0]   dREN,
   input  logic [CPUS-1:0]   dWEN,
   input  word_t             daddr  [CPUS],
   input  word_t             dstore [CPUS],
   output logic [CPUS-1:0]   dwait,
   output word_t             dload  [CPUS],
   output logic              ramREN,
   output logic              ramWEN,
   output word_t             ramaddr,
   output word_t             ramstore,
   input  word_t             ramload,
   input  ramstate_t         ramstate
);

   localparam int IDW = (CPUS > 1) ? $clog2(CPUS) : 1;
   typedef logic [IDW-1:0] id_t;

   arb_state_t      state;
   logic            owner_is_d;
   id_t             owner_id;
   id_t             rr_d;
   id_t             rr_i;

   logic [CPUS-1:0] d_req;
   logic            d_valid;
   logic            i_valid;
   id_t             d_idx;
   id_t             i_idx;
   logic            owner_req;
   logic            xfer_done;
   logic            xfer_drop;

   function automatic id_t next_id(input id_t id);
      if (int'(id) == CPUS - 1) return '0;
      return id + 1'b1;
   endfunction

   assign d_req = dREN | dWEN;

   rr_pick #(.N(CPUS), .IW(IDW)) u_pick_d (
      .req   (d_req),
      .ptr   (rr_d),
      .valid (d_valid),
      .idx   (d_idx)
   );

   rr_pick #(.N(CPUS), .IW(IDW)) u_pick_i (
      .req   (iREN),
      .ptr   (rr_i),
      .valid (i_valid),
      .idx   (i_idx)
   );

   // A completion needs the owner still asking; ACCESS with no request is treated as a drop.
   assign owner_req = owner_is_d ? d_req[owner_id] : iREN[owner_id];
   assign xfer_done = (state == XFER) && owner_req && (ramstate == ACCESS);
   assign xfer_drop = (state == XFER) && !owner_req;

   // Arbitration FSM: pick an owner in ARB, hold it through XFER until done or dropped.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= ARB;
         owner_is_d <= 1'b0;
         owner_id   <= '0;
         rr_d       <= '0;
         rr_i       <= '0;
      end else begin
         case (state)
            ARB: begin
               if (d_valid) begin
                  owner_is_d <= 1'b1;
                  owner_id   <= d_idx;
                  state      <= XFER;
               end else if (i_valid) begin
                  owner_is_d <= 1'b0;
                  owner_id   <= i_idx;
                  state      <= XFER;
               end
            end
            XFER: begin
               if (xfer_done) begin
                  if (!owner_is_d) begin
                     rr_i  <= next_id(owner_id);
                     state <= ARB;
                  end else if (daddr[owner_id][2]) begin
                     rr_d  <= next_id(owner_id);
                     state <= ARB;
                  end
               end else if (xfer_drop) begin
                  state <= ARB;
               end
            end
            default: state <= ARB;
         endcase
      end
   end

   // RAM-side mux and wait generation; idle values whenever not in XFER.
   always_comb begin
      iwait    = '1;
      dwait    = '1;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      if (state == XFER) begin
         if (owner_is_d) begin
            ramWEN   = dWEN[owner_id];
            ramREN   = dREN[owner_id] & ~dWEN[owner_id];
            ramaddr  = daddr[owner_id];
            ramstore = dstore[owner_id];
            if (xfer_done) dwait[owner_id] = 1'b0;
         end else begin
            ramREN  = iREN[owner_id];
            ramaddr = iaddr[owner_id];
            if (xfer_done) iwait[owner_id] = 1'b0;
         end
      end
   end

   // Load data is broadcast straight from the RAM.
   always_comb begin
      for (int c = 0; c < CPUS; c++) begin
         iload[c] = ramload;
         dload[c] = ramload;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with two cores.
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   logic       CLK;
   logic       RST;
   logic [1:0] iREN, dREN, dWEN, iwait, dwait;
   word_t      iaddr [2];
   word_t      iload [2];
   word_t      daddr [2];
   word_t      dstore [2];
   word_t      dload [2];
   logic       ramREN, ramWEN;
   word_t      ramaddr, ramstore, ramload;
   ramstate_t  ramstate;

   int n_cmp = 0;
   int n_err = 0;

   mem_arbiter #(.CPUS(2)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload),
      .dREN     (dREN),
      .dWEN     (dWEN),
      .daddr    (daddr),
      .dstore   (dstore),
      .dwait    (dwait),
      .dload    (dload),
      .ramREN   (ramREN),
      .ramWEN   (ramWEN),
      .ramaddr  (ramaddr),
      .ramstore (ramstore),
      .ramload  (ramload),
      .ramstate (ramstate)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Leaves the bench just after a rising edge with the DUT in ARB.
   task automatic do_reset();
      RST      = 1'b1;
      iREN     = '0;
      dREN     = '0;
      dWEN     = '0;
      for (int c = 0; c < 2; c++) begin
         iaddr[c]  = '0;
         daddr[c]  = '0;
         dstore[c] = '0;
      end
      ramload  = '0;
      ramstate = FREE;
      @(posedge CLK);
      @(negedge CLK);
      RST = 1'b0;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge CLK);
      n_cmp++; if (iwait !== 2'b11) begin n_err++; $display("FAIL rst_iwait got %b want 11", iwait); end
      n_cmp++; if (dwait !== 2'b11) begin n_err++; $display("FAIL rst_dwait got %b want 11", dwait); end
      n_cmp++; if ({ramREN, ramWEN} !== 2'b00) begin n_err++; $display("FAIL rst_strobes got %b want 00", {ramREN, ramWEN}); end
      n_cmp++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin n_err++; $display("FAIL rst_ram_bus got %h/%h want 0/0", ramaddr, ramstore); end
      n_cmp++; if (dut.state !== ARB || dut.rr_d !== 1'b0 || dut.rr_i !== 1'b0 || dut.owner_is_d !== 1'b0) begin
         n_err++; $display("FAIL rst_regs got st=%0d rr_d=%0d rr_i=%0d od=%0d want 0/0/0/0", dut.state, dut.rr_d, dut.rr_i, dut.owner_is_d);
      end
      @(posedge CLK); #1;
   endtask

   task automatic test_single_iread();
      do_reset();
      iREN[0]  = 1'b1;
      iaddr[0] = 32'h40;
      ramstate = ACCESS;
      ramload  = 32'hDEADBEEF;
      @(negedge CLK);
      n_cmp++; if (iwait !== 2'b11 || ramREN !== 1'b0) begin n_err++; $display("FAIL single_bubble got iwait=%b ren=%b want 11/0", iwait, ramREN); end
      @(posedge CLK); #1;
      @(negedge CLK);
      n_cmp++; if (ramaddr !== 32'h40 || ramREN !== 1'b1) begin n_err++; $display("FAIL single_addr got %h ren=%b want 40/1", ramaddr, ramREN); end
      n_cmp++; if (iwait !== 2'b10 || dwait !== 2'b11) begin n_err++; $display("FAIL single_wait got i=%b d=%b want 10/11", iwait, dwait); end
      n_cmp++; if (iload[0] !== 32'hDEADBEEF || dload[1] !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_load got %h/%h want deadbeef", iload[0], dload[1]); end
      @(posedge CLK); #1;
      iREN = '0;
      @(negedge CLK);
      n_cmp++; if (dut.state !== ARB || iwait !== 2'b11) begin n_err++; $display("FAIL single_back_arb got st=%0d iwait=%b want 0/11", dut.state, iwait); end
      @(posedge CLK); #1;
   endtask

   task automatic test_dcache_priority();
      do_reset();
      ramstate = ACCESS;
      iREN[1]  = 1'b1;
      iaddr[1] = 32'h300;
      dREN[0]  = 1'b1;
      daddr[0] = 32'h100;
      @(posedge CLK); #1;
      @(negedge CLK);
      n_cmp++; if (ramaddr !== 32'h100 || dwait !== 2'b10 || iwait !== 2'b11) begin
         n_err++; $display("FAIL prio_word0 got addr=%h d=%b i=%b want 100/10/11", ramaddr, dwait, iwait);
      end
      @(posedge CLK); #1;
      daddr[0] = 32'h104;
      @(negedge CLK);
      n_cmp++; if (ramaddr !== 32'h104 || dwait !== 2'b10 || iwait !== 2'b11) begin
         n_err++; $display("FAIL prio_word1 got addr=%h d=%b i=%b want 104/10/11", ramaddr, dwait, iwait);
      end
      @(posedge CLK); #1;
      dREN = '0;
      @(negedge CLK);
      n_cmp++; if (iwait !== 2'b11 || ramREN !== 1'b0) begin n_err++; $display("FAIL prio_bubble got i=%b ren=%b want 11/0", iwait, ramREN); end
      @(posedge CLK); #1;
      @(negedge CLK);
      n_cmp++; if (ramaddr !== 32'h300 || iwait !== 2'b01 || ramREN !== 1'b1) begin
         n_err++; $display("FAIL prio_icache got addr=%h i=%b ren=%b want 300/01/1", ramaddr, iwait, ramREN);
      end
      @(posedge CLK); #1;
      iREN = '0;
   endtask

   task automatic test_block_atomic();
      do_reset();
      ramstate  = ACCESS;
      dWEN[0]   = 1'b1;
      daddr[0]  = 32'h200;
      dstore[0] = 32'hA5A50001;
      dREN[1]   = 1'b1;
      daddr[1]  = 32'h500;
      @(posedge CLK); #1;
      @(negedge CLK);
      n_cmp++; if ({ramWEN, ramREN} !== 2'b10 || ramaddr !== 32'h200 || ramstore !== 32'hA5A50001 || dwait !== 2'b10) begin
         n_err++; $display("FAIL atomic_w0 got we/re=%b addr=%h st=%h d=%b want 10/200/a5a50001/10", {ramWEN, ramREN}, ramaddr, ramstore, dwait);
      end
      @(posedge CLK); #1;
      daddr[0]  = 32'h204;
      dstore[0] = 32'hA5A50002;
      @(negedge CLK);
      n_cmp++; if (ramaddr !== 32'h204 || ramstore !== 32'hA5A50002 || dwait !== 2'b10) begin
         n_err++; $display("FAIL atomic_w1 got addr=%h st=%h d=%b want 204/a5a50002/10", ramaddr, ramstore, dwait);
      end
      @(posedge CLK); #1;
      dWEN = '0;
      @(negedge CLK);
      n_cmp++; if (dut.rr_d !== 1'b1 || ramWEN !== 1'b0 || dwait !== 2'b11) begin
         n_err++; $display("FAIL atomic_ptr got rr_d=%0d we=%b d=%b want 1/0/11", dut.rr_d, ramWEN, dwait);
      end
      @(posedge CLK); #1;
      @(negedge CLK);
      n_cmp++; if (ramaddr !== 32'h500 || ramREN !== 1'b1 || dwait !== 2'b01) begin
         n_err++; $display("FAIL atomic_next got addr=%h re=%b d=%b want 500/1/01", ramaddr, ramREN, dwait);
      end
      // Owner drops its request mid-block: no completion, pointer untouched.
      @(posedge CLK); #1;
      dREN = '0;
      @(negedge CLK);
      n_cmp++; if (dwait !== 2'b11 || ramREN !== 1'b0) begin n_err++; $display("FAIL drop_wait got d=%b re=%b want 11/0", dwait, ramREN); end
      @(posedge CLK); #1;
      @(negedge CLK);
      n_cmp++; if (dut.state !== ARB || dut.rr_d !== 1'b1) begin n_err++; $display("FAIL drop_arb got st=%0d rr_d=%0d want 0/1", dut.state, dut.rr_d); end
      @(posedge CLK); #1;
   endtask

   task automatic test_round_robin();
      logic [1:0] wsel;
      logic [1:0] done_d;
      logic [1:0] exp_dw;
      word_t      exp_addr;
      do_reset();
      ramstate = ACCESS;
      dREN     = 2'b11;
      wsel     = 2'b00;
      for (int k = 0; k < 12; k++) begin
         daddr[0] = wsel[0] ? 32'h1004 : 32'h1000;
         daddr[1] = wsel[1] ? 32'h2004 : 32'h2000;
         @(negedge CLK);
         if (k % 3 == 0) exp_dw = 2'b11;
         else exp_dw = ((k / 3) % 2 == 0) ? 2'b10 : 2'b01;
         exp_addr = ((k / 3) % 2 == 0) ? 32'h1000 : 32'h2000;
         if (k % 3 == 2) exp_addr = exp_addr + 32'h4;
         n_cmp++; if (dwait !== exp_dw) begin n_err++; $display("FAIL rr_wait cyc%0d got %b want %b", k, dwait, exp_dw); end
         if (k % 3 != 0) begin
            n_cmp++; if (ramaddr !== exp_addr) begin n_err++; $display("FAIL rr_addr cyc%0d got %h want %h", k, ramaddr, exp_addr); end
         end
         done_d = ~dwait;
         @(posedge CLK); #1;
         wsel = wsel ^ done_d;
      end
      dREN = '0;
      @(posedge CLK); #1;
   endtask

   task automatic test_stall_error();
      do_reset();
      ramstate = BUSY;
      iREN[0]  = 1'b1;
      iaddr[0] = 32'h80;
      @(posedge CLK); #1;
      for (int k = 1; k <= 6; k++) begin
         ramstate = (k <= 3) ? BUSY : ((k <= 5) ? ERROR : ACCESS);
         @(negedge CLK);
         n_cmp++; if (iwait !== ((k == 6) ? 2'b10 : 2'b11)) begin
            n_err++; $display("FAIL stall_wait cyc%0d got %b want %b", k, iwait, (k == 6) ? 2'b10 : 2'b11);
         end
         n_cmp++; if (ramaddr !== 32'h80) begin n_err++; $display("FAIL stall_addr cyc%0d got %h want 80", k, ramaddr); end
         @(posedge CLK); #1;
      end
      iREN     = '0;
      ramstate = FREE;
      @(negedge CLK);
      n_cmp++; if (dut.state !== ARB || dut.rr_i !== 1'b1) begin n_err++; $display("FAIL stall_exit got st=%0d rr_i=%0d want 0/1", dut.state, dut.rr_i); end
      @(posedge CLK); #1;
   endtask

   // Runs without a fresh reset so rr_i is non-zero going in.
   task automatic test_reset_mid_xfer();
      ramstate  = BUSY;
      dWEN[1]   = 1'b1;
      daddr[1]  = 32'h600;
      dstore[1] = 32'h12345678;
      @(posedge CLK); #1;
      @(negedge CLK);
      n_cmp++; if (ramWEN !== 1'b1 || ramaddr !== 32'h600) begin n_err++; $display("FAIL rmid_pre got we=%b addr=%h want 1/600", ramWEN, ramaddr); end
      #2;
      RST = 1'b1;
      #1;
      n_cmp++; if (ramWEN !== 1'b0 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin
         n_err++; $display("FAIL rmid_async got we=%b addr=%h st=%h want 0/0/0", ramWEN, ramaddr, ramstore);
      end
      n_cmp++; if (iwait !== 2'b11 || dwait !== 2'b11) begin n_err++; $display("FAIL rmid_waits got i=%b d=%b want 11/11", iwait, dwait); end
      @(posedge CLK); #1;
      dWEN = '0;
      @(negedge CLK);
      RST = 1'b0;
      #1;
      n_cmp++; if (dut.state !== ARB || dut.rr_d !== 1'b0 || dut.rr_i !== 1'b0) begin
         n_err++; $display("FAIL rmid_regs got st=%0d rr_d=%0d rr_i=%0d want 0/0/0", dut.state, dut.rr_d, dut.rr_i);
      end
      @(posedge CLK); #1;
   endtask

   initial begin
      test_reset();
      test_single_iread();
      test_dcache_priority();
      test_block_atomic();
      test_round_robin();
      test_stall_error();
      test_reset_mid_xfer();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
